// File: rtl/link_delay_channel.sv
// link_delay_channel
//
// One direction of an inter-FPGA link. Words accepted on the input handshake
// come out of the output handshake in order. A word becomes visible exactly
// DELAY cycles after it is accepted. If the receiver stalls, it is released
// later than that.
//
// Parameters:
//   DATA_WIDTH - link word width
//   DELAY      - link latency in cycles; must be at least 1
//   DEPTH      - storage entries; must be a power of 2.
//                Full throughput needs DEPTH >= DELAY+1.
//
// Ports:
//   clk          - single clock; all state changes happen on its rising edge
//   reset        - asynchronous reset, active low
//   in_data      - word from the sender
//   in_valid     - sender offers in_data
//   in_ready     - channel can accept a word (occupancy < DEPTH)
//   out_data     - head word; reads 0 while out_valid is low
//   out_valid    - head word has matured
//   out_ready    - receiver accepts out_data
//   occupancy    - stored words, counting both in-flight and matured words
//   words_sent   - pop count, wraps at 2^32 (LINK_STATS_EN only, else 0)
//   stall_cycles - cycles with out_valid && !out_ready, saturating
//                  (LINK_STATS_EN only, else 0)
//
// Build option: define LINK_STATS_EN to include the two statistics counters.
// The port list is the same in both builds.

module link_delay_channel #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DELAY      = 53,
    parameter int unsigned DEPTH      = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [31:0]            words_sent,
    output logic [31:0]            stall_cycles
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      occ_q;
    logic [CNT_W-1:0]      occ_d;
    logic [CNT_W-1:0]      ripe_q;
    logic [CNT_W-1:0]      ripe_d;
    logic                  push;
    logic                  pop;
    logic                  ripe_inc;

    // Handshake flags come only from registered counters, so out_ready has
    // no combinational path to in_ready.
    assign in_ready  = (occ_q < FULL_CNT);
    assign out_valid = (ripe_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign occupancy = occ_q;

    // Maturity line: a one-bit pulse per push. The pulse leaves the last stage
    // DELAY-1 edges after the push and then bumps ripe_count. Maturity keeps
    // push order, so the head of the FIFO is always the oldest mature word.
    if (DELAY <= 1) begin : g_no_line
        assign ripe_inc = push;
    end else begin : g_line
        logic [DELAY-2:0] line_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                line_q <= '0;
            end else begin
                line_q[0] <= push;
                for (int i = 1; i < DELAY - 1; i++) begin
                    line_q[i] <= line_q[i-1];
                end
            end
        end

        assign ripe_inc = line_q[DELAY-2];
    end

    always_comb begin
        occ_d  = occ_q;
        ripe_d = ripe_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: ;
        endcase
        case ({ripe_inc, pop})
            2'b10:   ripe_d = ripe_q + 1'b1;
            2'b01:   ripe_d = ripe_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            ripe_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            occ_q  <= occ_d;
            ripe_q <= ripe_d;
        end
    end

    // Storage needs no reset: out_data is gated by out_valid, and reset clears
    // ripe_count, so a stale entry can never be presented.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

`ifdef LINK_STATS_EN
    logic [31:0] words_sent_q;
    logic [31:0] stall_cycles_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            words_sent_q   <= '0;
            stall_cycles_q <= '0;
        end else begin
            if (pop) words_sent_q <= words_sent_q + 32'd1;
            if (out_valid && !out_ready && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
        end
    end

    assign words_sent   = words_sent_q;
    assign stall_cycles = stall_cycles_q;
`else
    assign words_sent   = '0;
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_link_delay_channel.sv
// Directed self-checking bench for link_delay_channel.
// dut  : DELAY=53, DEPTH=64, 64-bit words
// dut1 : DELAY=1,  DEPTH=2,  8-bit words
// Inputs are driven and outputs sampled 1 time unit after a rising edge.

module tb_link_delay_channel;

    logic        clk;
    logic        reset;

    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  occupancy;
    logic [31:0] words_sent;
    logic [31:0] stall_cycles;

    logic [7:0]  d1_in_data;
    logic        d1_in_valid;
    logic        d1_in_ready;
    logic [7:0]  d1_out_data;
    logic        d1_out_valid;
    logic        d1_out_ready;
    logic [1:0]  d1_occupancy;
    logic [31:0] d1_words_sent;
    logic [31:0] d1_stall_cycles;

    int n_cmp;
    int n_bad;

    link_delay_channel #(.DATA_WIDTH(64), .DELAY(53), .DEPTH(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .occupancy    (occupancy),
        .words_sent   (words_sent),
        .stall_cycles (stall_cycles)
    );

    link_delay_channel #(.DATA_WIDTH(8), .DELAY(1), .DEPTH(2)) dut1 (
        .clk          (clk),
        .reset        (reset),
        .in_data      (d1_in_data),
        .in_valid     (d1_in_valid),
        .in_ready     (d1_in_ready),
        .out_data     (d1_out_data),
        .out_valid    (d1_out_valid),
        .out_ready    (d1_out_ready),
        .occupancy    (d1_occupancy),
        .words_sent   (d1_words_sent),
        .stall_cycles (d1_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        d1_in_data = '0; d1_in_valid = 1'b0; d1_out_ready = 1'b0;
        #12;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 64'h0) begin n_bad++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
        n_cmp++; if (occupancy !== 7'd0) begin n_bad++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
        n_cmp++; if (words_sent !== 32'd0) begin n_bad++; $display("FAIL reset_words_sent: got %0d want 0", words_sent); end
        n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL reset_stall_cycles: got %0d want 0", stall_cycles); end
        n_cmp++; if (d1_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_d1_in_ready: got %b want 1", d1_in_ready); end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_single_word();
        do_reset();
        in_data = 64'h1; in_valid = 1'b1; out_ready = 1'b1;
        tick();  // edge k: push
        in_valid = 1'b0; in_data = '0;
        n_cmp++; if (occupancy !== 7'd1) begin n_bad++; $display("FAIL single_occ_after_push: got %0d want 1", occupancy); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_k: got %b want 0", out_valid); end
        for (int i = 1; i <= 51; i++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_valid: edge k+%0d got %b want 0", i, out_valid); end
        end
        tick();  // edge k+52: matures
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid_k52: got %b want 1", out_valid); end
        n_cmp++; if (out_data !== 64'h1) begin n_bad++; $display("FAIL single_data: got %0h want 1", out_data); end
        n_cmp++; if (occupancy !== 7'd1) begin n_bad++; $display("FAIL single_occ_k52: got %0d want 1", occupancy); end
        tick();  // edge k+53: pop
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_after_pop: got %b want 0", out_valid); end
        n_cmp++; if (occupancy !== 7'd0) begin n_bad++; $display("FAIL single_occ_after_pop: got %0d want 0", occupancy); end
        n_cmp++; if (out_data !== 64'h0) begin n_bad++; $display("FAIL single_data_after_pop: got %0h want 0", out_data); end
    endtask

    // Word c is pushed at edge c and must pop at edge c+53.
    task automatic test_streaming();
        logic exp_v;
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 160; c++) begin
            exp_v = (c >= 53) && (c < 153);
            if (c < 100) begin
                n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_in_ready: c=%0d got %b want 1", c, in_ready); end
            end
            n_cmp++; if (out_valid !== exp_v) begin n_bad++; $display("FAIL stream_valid: c=%0d got %b want %b", c, out_valid, exp_v); end
            if (exp_v) begin
                n_cmp++; if (out_data !== 64'(c - 53)) begin n_bad++; $display("FAIL stream_data: c=%0d got %0d want %0d", c, out_data, c - 53); end
            end
            in_valid = (c < 100);
            in_data  = 64'(c);
            tick();
        end
        in_valid = 1'b0;
        n_cmp++; if (occupancy !== 7'd0) begin n_bad++; $display("FAIL stream_occ_end: got %0d want 0", occupancy); end
    endtask

    task automatic test_full();
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 64; c++) begin
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL full_in_ready_fill: c=%0d got %b want 1", c, in_ready); end
            in_valid = 1'b1;
            in_data  = 64'h100 + 64'(c);
            tick();
        end
        n_cmp++; if (occupancy !== 7'd64) begin n_bad++; $display("FAIL full_occ: got %0d want 64", occupancy); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        // Offer a word while full; it must be ignored.
        in_data = 64'h999;
        for (int i = 0; i < 60; i++) tick();
        in_valid = 1'b0;
        n_cmp++; if (occupancy !== 7'd64) begin n_bad++; $display("FAIL full_occ_hold: got %0d want 64", occupancy); end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL full_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_data !== 64'h100) begin n_bad++; $display("FAIL full_head: got %0h want 100", out_data); end
        out_ready = 1'b1;
        for (int p = 0; p < 64; p++) begin
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL full_drain_valid: p=%0d got %b want 1", p, out_valid); end
            n_cmp++; if (out_data !== 64'h100 + 64'(p)) begin n_bad++; $display("FAIL full_drain_data: p=%0d got %0h want %0h", p, out_data, 64'h100 + 64'(p)); end
            tick();
            if (p == 0) begin
                n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL full_in_ready_after_pop: got %b want 1", in_ready); end
                n_cmp++; if (occupancy !== 7'd63) begin n_bad++; $display("FAIL full_occ_after_pop: got %0d want 63", occupancy); end
            end
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL full_valid_end: got %b want 0", out_valid); end
        n_cmp++; if (occupancy !== 7'd0) begin n_bad++; $display("FAIL full_occ_end: got %0d want 0", occupancy); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_data  = 64'h200 + 64'(c);
            tick();
        end
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (occupancy !== 7'd0) begin n_bad++; $display("FAIL mid_reset_occ: got %0d want 0", occupancy); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_data !== 64'h0) begin n_bad++; $display("FAIL mid_reset_data: got %0h want 0", out_data); end
        tick();
        reset = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_stale: cycle %0d got valid %b data %0h want 0", i, out_valid, out_data); end
        end
        n_cmp++; if (occupancy !== 7'd0) begin n_bad++; $display("FAIL mid_reset_occ_end: got %0d want 0", occupancy); end
    endtask

    task automatic test_delay1();
        logic exp_v;
        do_reset();
        d1_out_ready = 1'b1;
        d1_in_data = 8'hA5; d1_in_valid = 1'b1;
        tick();  // edge k: push
        d1_in_valid = 1'b0;
        n_cmp++; if (d1_out_valid !== 1'b1) begin n_bad++; $display("FAIL d1_valid: got %b want 1", d1_out_valid); end
        n_cmp++; if (d1_out_data !== 8'hA5) begin n_bad++; $display("FAIL d1_data: got %0h want a5", d1_out_data); end
        n_cmp++; if (d1_occupancy !== 2'd1) begin n_bad++; $display("FAIL d1_occ: got %0d want 1", d1_occupancy); end
        tick();  // edge k+1: pop
        n_cmp++; if (d1_out_valid !== 1'b0) begin n_bad++; $display("FAIL d1_valid_after_pop: got %b want 0", d1_out_valid); end
        n_cmp++; if (d1_occupancy !== 2'd0) begin n_bad++; $display("FAIL d1_occ_after_pop: got %0d want 0", d1_occupancy); end
        // Word c pushed at edge c pops at edge c+1.
        for (int c = 0; c < 22; c++) begin
            exp_v = (c >= 1) && (c <= 20);
            if (c < 20) begin
                n_cmp++; if (d1_in_ready !== 1'b1) begin n_bad++; $display("FAIL d1_stream_ready: c=%0d got %b want 1", c, d1_in_ready); end
            end
            n_cmp++; if (d1_out_valid !== exp_v) begin n_bad++; $display("FAIL d1_stream_valid: c=%0d got %b want %b", c, d1_out_valid, exp_v); end
            if (exp_v) begin
                n_cmp++; if (d1_out_data !== 8'(8'h10 + c - 1)) begin n_bad++; $display("FAIL d1_stream_data: c=%0d got %0h want %0h", c, d1_out_data, 8'(8'h10 + c - 1)); end
            end
            d1_in_valid = (c < 20);
            d1_in_data  = 8'(8'h10 + c);
            tick();
        end
        d1_in_valid = 1'b0;
        n_cmp++; if (d1_occupancy !== 2'd0) begin n_bad++; $display("FAIL d1_occ_end: got %0d want 0", d1_occupancy); end
    endtask

    task automatic test_stats();
        int          waited;
        logic [31:0] exp_stall;
        logic [31:0] exp_sent;
`ifdef LINK_STATS_EN
        exp_stall = 32'd7;
        exp_sent  = 32'd1;
`else
        exp_stall = 32'd0;
        exp_sent  = 32'd0;
`endif
        do_reset();
        out_ready = 1'b0;
        in_data = 64'h77; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        waited = 0;
        while (!out_valid && waited < 100) begin
            tick();
            waited++;
        end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stats_wait_valid: got %b want 1 within 100 cycles", out_valid); end
        n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL stats_stall_pre: got %0d want 0", stall_cycles); end
        for (int i = 0; i < 7; i++) tick();
        n_cmp++; if (out_data !== 64'h77) begin n_bad++; $display("FAIL stats_held_data: got %0h want 77", out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (stall_cycles !== exp_stall) begin n_bad++; $display("FAIL stats_stall: got %0d want %0d", stall_cycles, exp_stall); end
        n_cmp++; if (words_sent !== exp_sent) begin n_bad++; $display("FAIL stats_sent: got %0d want %0d", words_sent, exp_sent); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stats_valid_end: got %b want 0", out_valid); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single_word();
        test_streaming();
        test_full();
        test_reset_mid();
        test_delay1();
        test_stats();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
